// File: rtl/jtframe_ddram_bram_resp_if.sv
// MiSTer-style DDRAM burst port bundle shared by a jtframe DDR initiator and its responder.
// The initiator drives command/write fields; the responder returns busy and read data.
interface jtframe_ddram_bram_resp_if;
    logic [7:0]  burstcnt;
    logic [28:0] addr;
    logic        rd;
    logic        we;
    logic [63:0] din;
    logic [7:0]  be;
    logic        busy;
    logic [63:0] dout;
    logic        dout_ready;

    modport master (
        output burstcnt, addr, rd, we, din, be,
        input  busy, dout, dout_ready
    );

    modport slave (
        input  burstcnt, addr, rd, we, din, be,
        output busy, dout, dout_ready
    );
endinterface

// File: rtl/jtframe_ddram_bram_resp.sv
// BRAM-backed responder for the DDRAM burst port, so DDR initiators can run without external DDR.
// Handles read/write bursts, byte enables, programmable read latency and optional periodic stalls.
module jtframe_ddram_bram_resp #(
    parameter int AW      = 10,
    parameter int LATENCY = 4,
    parameter int STALL   = 0
)(
    input  logic                     clk,
    input  logic                     rst,
    jtframe_ddram_bram_resp_if.slave ddram,
    output logic                     err
);
    typedef enum logic [1:0] {IDLE, WR_BURST, RD_WAIT, RD_BURST} state_t;

    localparam logic [3:0]    LAT_LAST  = 4'(LATENCY - 1);
    localparam logic [15:0]   STALL_TOP = (STALL > 0) ? 16'(STALL - 1) : 16'd0;
    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);

    state_t        state_q, state_nx;
    logic [AW-1:0] base_q;
    logic [8:0]    remaining_q;
    logic [3:0]    lat_q;
    logic [15:0]   stall_q, stall_cnt_nx;
    logic          stall_now, stall_next;
    logic [63:0]   dout_q;
    logic          ready_q;
    logic [63:0]   mem [0:(1<<AW)-1];

    logic [AW-1:0] addr_local, wr_addr;
    logic [8:0]    burst_len;
    logic          accept_we, accept_rd;
    logic          wr_en, load_wr, load_rd, rd_step, set_err;
    logic          unused_addr;

    assign addr_local  = ddram.addr[AW-1:0];
    assign unused_addr = ^ddram.addr[28:AW];
    assign burst_len   = {ddram.burstcnt == 8'd0, ddram.burstcnt};

    // A stall cycle is the one where the free-running counter sits at its top value
    always_comb begin
        stall_cnt_nx = 16'd0;
        if (STALL > 0 && stall_q != STALL_TOP)
            stall_cnt_nx = stall_q + 16'd1;
        stall_now  = (STALL > 0) && (stall_q == STALL_TOP);
        stall_next = (STALL > 0) && (stall_cnt_nx == STALL_TOP);
    end

    assign ddram.busy       = (state_q == RD_WAIT) || (state_q == RD_BURST) || stall_now;
    assign ddram.dout       = dout_q;
    assign ddram.dout_ready = ready_q;
    assign accept_we        = ddram.we && !ddram.busy;
    assign accept_rd        = ddram.rd && !ddram.busy;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        wr_en    = 1'b0;
        wr_addr  = base_q;
        load_wr  = 1'b0;
        load_rd  = 1'b0;
        rd_step  = 1'b0;
        set_err  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_we) begin
                    wr_en   = 1'b1;
                    wr_addr = addr_local;
                    load_wr = 1'b1;
                    set_err = ddram.rd;
                    if (burst_len != 9'd1) state_nx = WR_BURST;
                end else if (accept_rd) begin
                    load_rd  = 1'b1;
                    state_nx = RD_WAIT;
                end
            end
            WR_BURST: begin
                if (accept_we) begin
                    wr_en = 1'b1;
                    if (remaining_q == 9'd1) state_nx = IDLE;
                end
                if (accept_rd) set_err = 1'b1;
            end
            RD_WAIT: begin
                if (lat_q == LAT_LAST) state_nx = RD_BURST;
            end
            RD_BURST: begin
                // Hold the word back if the cycle it would appear in is a stall cycle
                if (!stall_next) begin
                    rd_step = 1'b1;
                    if (remaining_q == 9'd1) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= '0;
            remaining_q <= '0;
            lat_q       <= '0;
            stall_q     <= '0;
            dout_q      <= '0;
            ready_q     <= 1'b0;
            err         <= 1'b0;
        end else begin
            stall_q <= stall_cnt_nx;
            ready_q <= rd_step;
            if (set_err) err <= 1'b1;
            if (load_wr) begin
                remaining_q <= burst_len - 9'd1;
                base_q      <= addr_local + ADDR_ONE;
            end else if (load_rd) begin
                remaining_q <= burst_len;
                base_q      <= addr_local;
                lat_q       <= 4'd1;
            end else if (wr_en) begin
                remaining_q <= remaining_q - 9'd1;
                base_q      <= base_q + ADDR_ONE;
            end else if (rd_step) begin
                dout_q      <= mem[base_q];
                remaining_q <= remaining_q - 9'd1;
                base_q      <= base_q + ADDR_ONE;
            end
            if (state_q == RD_WAIT) lat_q <= lat_q + 4'd1;
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++)
                if (ddram.be[i]) mem[wr_addr][8*i +: 8] <= ddram.din[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_jtframe_ddram_bram_resp.sv
// Directed self-checking bench for jtframe_ddram_bram_resp: one DUT without stalls, one with STALL=3.
module tb_jtframe_ddram_bram_resp;
    logic clk;
    logic rst;
    logic err0, err3;

    jtframe_ddram_bram_resp_if if0();
    jtframe_ddram_bram_resp_if if3();
    virtual jtframe_ddram_bram_resp_if vif;

    jtframe_ddram_bram_resp #(.AW(10), .LATENCY(4), .STALL(0)) dut0 (
        .clk(clk), .rst(rst), .ddram(if0), .err(err0)
    );
    jtframe_ddram_bram_resp #(.AW(10), .LATENCY(4), .STALL(3)) dut3 (
        .clk(clk), .rst(rst), .ddram(if3), .err(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected stall phase for the STALL=3 instance: busy on every third cycle after reset
    logic [1:0] mcnt;
    always @(posedge clk) begin
        if (rst) mcnt <= 2'd0;
        else     mcnt <= (mcnt == 2'd2) ? 2'd0 : mcnt + 2'd1;
    end

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] rdata [0:255];
    int rcount, first_lat, rd_gap, stall_ready;
    int wr_beats, wr_busy, wr_stall_err;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Write burst with data seed+i, holding we across busy cycles
    task automatic applyStimulus(input logic [28:0] a, input int n, input logic [7:0] be,
                                 input logic [63:0] seed);
        int i, k;
        logic b;
        i = 0; k = 0;
        wr_busy = 0; wr_stall_err = 0;
        vif.addr = a; vif.burstcnt = n[7:0]; vif.be = be; vif.we = 1'b1;
        while (i < n && k < 4000) begin
            vif.din = seed + 64'(i);
            b = vif.busy;
            if (b) wr_busy++;
            if (b != (mcnt == 2'd2)) wr_stall_err++;
            @(posedge clk); #1;
            k++;
            if (!b) i++;
        end
        vif.we = 1'b0;
        wr_beats = i;
    endtask

    task automatic applyRead(input logic [28:0] a, input int n);
        int k;
        rcount = 0; first_lat = -1; rd_gap = 0; stall_ready = 0;
        vif.addr = a; vif.burstcnt = n[7:0]; vif.rd = 1'b1;
        k = 0;
        while (vif.busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        vif.rd = 1'b0;
        for (int c = 1; c <= 2000 && rcount < n; c++) begin
            @(posedge clk); #1;
            if (vif.dout_ready) begin
                if (rcount == 0) first_lat = c;
                rdata[rcount] = vif.dout;
                rcount++;
                if (mcnt == 2'd2) stall_ready++;
            end else if (rcount > 0) begin
                rd_gap++;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int pulses;
        rst = 1'b1;
        if0.rd = 0; if0.we = 0; if0.addr = 0; if0.burstcnt = 0; if0.din = 0; if0.be = 0;
        if3.rd = 0; if3.we = 0; if3.addr = 0; if3.burstcnt = 0; if3.din = 0; if3.be = 0;
        vif = if0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        checkOutput("rst_busy",  64'(if0.busy), 64'd0);
        checkOutput("rst_ready", 64'(if0.dout_ready), 64'd0);
        checkOutput("rst_dout",  if0.dout, 64'd0);
        checkOutput("rst_err",   64'(err0), 64'd0);

        $display("[TB] basic write/read burst");
        applyStimulus(29'h10, 4, 8'hFF, 64'd1);
        checkOutput("t1_wr_beats", 64'(wr_beats), 64'd4);
        checkOutput("t1_wr_busy",  64'(wr_busy), 64'd0);
        applyRead(29'h10, 4);
        checkOutput("t1_rd_count", 64'(rcount), 64'd4);
        checkOutput("t1_latency",  64'(first_lat), 64'd4);
        checkOutput("t1_rd_gap",   64'(rd_gap), 64'd0);
        for (int i = 0; i < 4; i++) checkOutput("t1_word", rdata[i], 64'(i + 1));

        $display("[TB] byte enables");
        applyStimulus(29'h20, 1, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        applyStimulus(29'h20, 1, 8'h03, 64'h1234);
        applyRead(29'h20, 1);
        checkOutput("t2_count", 64'(rcount), 64'd1);
        checkOutput("t2_word",  rdata[0], 64'hFFFF_FFFF_FFFF_1234);

        $display("[TB] 256-beat wrapping burst");
        applyStimulus(29'h3FF, 256, 8'hFF, 64'h3000);
        checkOutput("t3_wr_beats", 64'(wr_beats), 64'd256);
        applyRead(29'h3FF, 256);
        checkOutput("t3_rd_count", 64'(rcount), 64'd256);
        for (int i = 0; i < 256; i++) checkOutput("t3_word", rdata[i], 64'h3000 + 64'(i));
        applyRead(29'h000, 1);
        checkOutput("t3_wrap_word", rdata[0], 64'h3001);
        checkOutput("t3_err", 64'(err0), 64'd0);

        $display("[TB] stalled line-buffer transfer");
        vif = if3;
        applyStimulus(29'h100, 128, 8'h03, 64'hA000);
        checkOutput("t4_wr_beats",   64'(wr_beats), 64'd128);
        checkOutput("t4_busy_phase", 64'(wr_stall_err), 64'd0);
        checkOutput("t4_saw_stall",  64'(wr_busy > 0), 64'd1);
        applyRead(29'h100, 128);
        checkOutput("t4_rd_count",   64'(rcount), 64'd128);
        checkOutput("t4_ready_stall", 64'(stall_ready), 64'd0);
        for (int i = 0; i < 128; i++)
            checkOutput("t4_word", rdata[i] & 64'hFFFF, 64'(16'hA000 + 16'(i)));
        checkOutput("t4_err", 64'(err3), 64'd0);

        $display("[TB] reset during read burst");
        vif = if0;
        applyStimulus(29'h80, 8, 8'hFF, 64'h800);
        if0.addr = 29'h80; if0.burstcnt = 8'd8; if0.rd = 1'b1;
        @(posedge clk); #1;
        if0.rd = 1'b0;
        pulses = 0;
        for (int c = 0; c < 50 && pulses < 2; c++) begin
            @(posedge clk); #1;
            if (if0.dout_ready) pulses++;
        end
        checkOutput("t6_pulses", 64'(pulses), 64'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t6_busy",  64'(if0.busy), 64'd0);
        checkOutput("t6_ready", 64'(if0.dout_ready), 64'd0);
        checkOutput("t6_err",   64'(err0), 64'd0);
        applyRead(29'h80, 8);
        checkOutput("t6_rd_count", 64'(rcount), 64'd8);
        for (int i = 0; i < 8; i++) checkOutput("t6_word", rdata[i], 64'h800 + 64'(i));

        $display("[TB] simultaneous rd and we");
        if0.addr = 29'h40; if0.burstcnt = 8'd1; if0.din = 64'h5555; if0.be = 8'hFF;
        if0.we = 1'b1; if0.rd = 1'b1;
        @(posedge clk); #1;
        if0.we = 1'b0; if0.rd = 1'b0;
        checkOutput("t5_err_set", 64'(err0), 64'd1);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (if0.dout_ready) pulses++;
            @(posedge clk); #1;
        end
        checkOutput("t5_no_rdata", 64'(pulses), 64'd0);
        applyRead(29'h40, 1);
        checkOutput("t5_word", rdata[0], 64'h5555);
        checkOutput("t5_err_sticky", 64'(err0), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checkOutput("t5_err_clear", 64'(err0), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
